// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: fetch FSM states, instruction size and reset vector.
package riscv_pkg;
    localparam int XLEN = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [2:0] {
        BOOT,
        REQ,
        WAIT,
        HOLD,
        HALT
    } fetch_state_e;
endpackage

// File: rtl/fetch_pc_ctrl.sv
// PC sequencer and single-outstanding instruction fetch controller with a
// one-entry hand-off buffer to decode and redirect/squash handling.
module fetch_pc_ctrl
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            instr_valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    input  logic            instr_ready_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            flush_o,
    output logic            misalign_o
);

    fetch_state_e    state;
    logic [XLEN-1:0] pc;
    logic            kill;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] instr_pc_q;
    logic            flush_q;
    logic            misalign_q;

    logic redirect_live;
    logic redirect_bad;

    assign redirect_live = redirect_valid_i && (state == REQ || state == WAIT || state == HOLD);
    assign redirect_bad  = redirect_pc_i[1:0] != 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            kill       <= 1'b0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            flush_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            flush_q <= 1'b0;
            if (redirect_live) begin
                flush_q <= 1'b1;
                if (redirect_bad) begin
                    // Fatal: any in-flight response is simply never consumed.
                    state      <= HALT;
                    misalign_q <= 1'b1;
                    kill       <= 1'b0;
                end else begin
                    pc <= redirect_pc_i;
                    case (state)
                        REQ: begin
                            if (imem_gnt_i) begin
                                kill  <= 1'b1;
                                state <= WAIT;
                            end
                        end
                        WAIT: begin
                            if (imem_rvalid_i) begin
                                kill  <= 1'b0;
                                state <= REQ;
                            end else begin
                                kill <= 1'b1;
                            end
                        end
                        default: state <= REQ;
                    endcase
                end
            end else begin
                case (state)
                    BOOT: state <= REQ;
                    REQ: if (imem_gnt_i) state <= WAIT;
                    WAIT: begin
                        if (imem_rvalid_i) begin
                            if (kill) begin
                                kill  <= 1'b0;
                                state <= REQ;
                            end else begin
                                instr_q    <= imem_rdata_i;
                                instr_pc_q <= pc;
                                pc         <= pc + XLEN'(INSTR_BYTES);
                                state      <= HOLD;
                            end
                        end
                    end
                    HOLD: if (instr_ready_i) state <= REQ;
                    default: state <= state;
                endcase
            end
        end
    end

    assign imem_req_o    = (state == REQ);
    assign imem_addr_o   = pc;
    assign instr_valid_o = (state == HOLD);
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign flush_o       = flush_q;
    assign misalign_o    = misalign_q;

endmodule
